quad_decoder_16: RTL and testbench

- Quadrature encoder front end that drives the control inputs of lpm_counter_16_16 (Cnt_En, UpDown, Sclr).
- Synchronises and glitch-filters asynchronous A/B/Index inputs, then decodes x4 quadrature edges into one-cycle count pulses with direction.
- Flags illegal transitions and generates a synchronous index clear, so the downstream counter holds absolute position.

---
 rtl/quad_pkg.sv | 52 +++++
 rtl/quad_glitch_filter.sv | 78 +++++++
 rtl/quad_decoder_16.sv | 134 +++++++++++++
 tb/tb_quad_decoder_16.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared constants and step classification for the quadrature decoder.
// AB states are packed as {A, B}; the up direction has channel A leading.
package quad_pkg;

  localparam int FILT_W = 4;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_ERR
  } step_e;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } dec_state_e;

  // Successor of an AB state when rotating in the up direction.
  function automatic logic [1:0] next_up(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      QS_00:   nxt = QS_10;
      QS_10:   nxt = QS_11;
      QS_11:   nxt = QS_01;
      default: nxt = QS_00;
    endcase
    return nxt;
  endfunction

  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e st;
    if (prev == cur)
      st = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      st = STEP_ERR;
    else if (next_up(prev) == cur)
      st = STEP_UP;
    else
      st = STEP_DN;
    return st;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Synchroniser followed by a stable-count glitch filter for one raw input.
// Also reports when the synced input has held one level for FILT_LEN samples.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic Clock,
  input  logic Sclr,
  input  logic i_raw,
  output logic o_filt,
  output logic o_filt_next,
  output logic o_stable
);

  localparam logic [FILT_W-1:0] LP_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [FILT_W-1:0] LP_LEN  = FILT_W'(FILT_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [FILT_W-1:0]      r_cnt;
  logic [FILT_W-1:0]      r_run;
  logic                   r_filt;
  logic                   r_last;

  logic [FILT_W-1:0]      w_cnt_next;
  logic [FILT_W-1:0]      w_run_next;
  logic                   w_synced;
  logic                   w_filled;
  logic                   w_differs;
  logic                   w_take;

  always_comb begin
    w_synced  = r_sync[SYNC_STAGES-1];
    w_filled  = r_fill[SYNC_STAGES-1];
    w_differs = (w_synced != r_filt);
    w_take    = w_differs && (r_cnt == LP_LAST);

    if (!w_differs || w_take)
      w_cnt_next = '0;
    else
      w_cnt_next = r_cnt + 1'b1;

    // Run length of identical synced samples, only once the sync chain holds real data.
    w_run_next = r_run;
    if (w_filled) begin
      if ((r_run == '0) || (w_synced != r_last))
        w_run_next = FILT_W'(1);
      else if (r_run != LP_LEN)
        w_run_next = r_run + 1'b1;
    end

    o_filt      = r_filt;
    o_filt_next = w_take ? w_synced : r_filt;
    o_stable    = w_filled && (w_run_next == LP_LEN);
  end

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      r_sync <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_run  <= '0;
      r_filt <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_cnt  <= w_cnt_next;
      r_run  <= w_run_next;
      r_last <= w_synced;
      if (w_take)
        r_filt <= w_synced;
    end
  end

endmodule

// File: rtl/quad_decoder_16.sv
// Quadrature x4 decoder: filtered A/B/Idx in, one-cycle count/clear pulses out
// for a downstream position counter, plus a sticky illegal-transition flag.
module quad_decoder_16
  import quad_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Sclr,
  input  logic A,
  input  logic B,
  input  logic Idx,
  input  logic Idx_En,
  input  logic Err_Clr,
  output logic Cnt_En,
  output logic UpDown,
  output logic Cnt_Sclr,
  output logic Ready,
  output logic Err
);

  logic [2:0] w_raw;
  logic [2:0] w_filt;
  logic [2:0] w_filt_next;
  logic [2:0] w_stable;

  assign w_raw = {Idx, B, A};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
      ) u_filt (
        .Clock       (Clock),
        .Sclr        (Sclr),
        .i_raw       (w_raw[gi]),
        .o_filt      (w_filt[gi]),
        .o_filt_next (w_filt_next[gi]),
        .o_stable    (w_stable[gi])
      );
    end
  endgenerate

  // The index channel only needs its filtered level.
  logic w_unused_idx;
  assign w_unused_idx = &{1'b0, w_filt_next[2], w_stable[2]};

  dec_state_e r_state;
  logic [1:0] r_prev;
  logic       r_cnt_en;
  logic       r_updown;
  logic       r_cnt_sclr;
  logic       r_err;
  logic       r_idx_prev;

  dec_state_e w_state_next;
  logic [1:0] w_prev_next;
  logic       w_cnt_en_next;
  logic       w_updown_next;
  logic       w_cnt_sclr_next;
  logic       w_err_next;
  logic [1:0] w_ab;
  logic [1:0] w_ab_next;
  step_e      w_step;

  always_comb begin
    w_ab            = {w_filt[0], w_filt[1]};
    w_ab_next       = {w_filt_next[0], w_filt_next[1]};
    w_step          = quad_step(r_prev, w_ab);

    w_state_next    = r_state;
    w_prev_next     = r_prev;
    w_cnt_en_next   = 1'b0;
    w_updown_next   = r_updown;
    w_err_next      = r_err & ~Err_Clr;
    w_cnt_sclr_next = w_filt[2] & ~r_idx_prev & Idx_En;

    case (r_state)
      ST_PRIME: begin
        // Capture the level the filters settle on this edge so priming never counts.
        if (w_stable[0] && w_stable[1]) begin
          w_state_next = ST_RUN;
          w_prev_next  = w_ab_next;
        end
      end
      ST_RUN: begin
        w_prev_next = w_ab;
        case (w_step)
          STEP_UP: begin
            w_cnt_en_next = 1'b1;
            w_updown_next = DIR_UP;
          end
          STEP_DN: begin
            w_cnt_en_next = 1'b1;
            w_updown_next = DIR_DN;
          end
          STEP_ERR: w_err_next = 1'b1;
          default: ;
        endcase
      end
      default: w_state_next = ST_PRIME;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      r_state    <= ST_PRIME;
      r_prev     <= QS_00;
      r_cnt_en   <= 1'b0;
      r_updown   <= DIR_UP;
      r_cnt_sclr <= 1'b0;
      r_err      <= 1'b0;
      r_idx_prev <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prev     <= w_prev_next;
      r_cnt_en   <= w_cnt_en_next;
      r_updown   <= w_updown_next;
      r_cnt_sclr <= w_cnt_sclr_next;
      r_err      <= w_err_next;
      r_idx_prev <= w_filt[2];
    end
  end

  assign Cnt_En   = r_cnt_en;
  assign UpDown   = r_updown;
  assign Cnt_Sclr = r_cnt_sclr;
  assign Ready    = (r_state == ST_RUN);
  assign Err      = r_err;

endmodule

// File: tb/tb_quad_decoder_16.sv
// Bench for quad_decoder_16: directed scenarios plus random A/B/Idx traffic,
// checked every cycle against a sample-history reference model.
module tb_quad_decoder_16;

  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic Clock   = 1'b0;
  logic Sclr    = 1'b1;
  logic A       = 1'b0;
  logic B       = 1'b0;
  logic Idx     = 1'b0;
  logic Idx_En  = 1'b0;
  logic Err_Clr = 1'b0;
  logic Cnt_En, UpDown, Cnt_Sclr, Ready, Err;

  int n_checks = 0;
  int n_fail   = 0;

  quad_decoder_16 #(.FILT_LEN(FILT), .SYNC_STAGES(SYNC)) dut (
    .Clock    (Clock),
    .Sclr     (Sclr),
    .A        (A),
    .B        (B),
    .Idx      (Idx),
    .Idx_En   (Idx_En),
    .Err_Clr  (Err_Clr),
    .Cnt_En   (Cnt_En),
    .UpDown   (UpDown),
    .Cnt_Sclr (Cnt_Sclr),
    .Ready    (Ready),
    .Err      (Err)
  );

  always #5 Clock = ~Clock;

  // Reference model: raw samples per edge since reset, and the levels they imply.
  logic [2:0] rawq[$];
  int   m_n;
  bit   m_f[3];
  bit   [1:0] m_prev;
  bit   m_ready, m_idx_prev, m_cnt_en, m_updown, m_cnt_sclr, m_err;

  // Downstream counter image built from the DUT's outputs, plus pulse tallies.
  logic [15:0] tb_pos = 16'h0000;
  int n_up = 0, n_dn = 0, n_clr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit syn(int e, int ch);
    if (e - SYNC >= 1) return rawq[e - SYNC][ch];
    return 1'b0;
  endfunction

  function automatic int phase(bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit window_const(int ch);
    bit v = syn(m_n, ch);
    for (int k = 1; k < FILT; k++)
      if (syn(m_n - k, ch) != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit illegal;
    bit flip;
    bit [1:0] cur;
    int d;
    if (Sclr) begin
      m_n = 0;
      rawq.delete();
      rawq.push_back(3'b000);
      for (int c = 0; c < 3; c++) m_f[c] = 1'b0;
      m_ready = 0; m_prev = 2'b00; m_idx_prev = 0;
      m_cnt_en = 0; m_updown = 1; m_cnt_sclr = 0; m_err = 0;
      return;
    end
    m_n++;
    rawq.push_back({Idx, B, A});
    illegal  = 1'b0;
    m_cnt_en = 1'b0;
    cur = {m_f[0], m_f[1]};
    if (m_ready) begin
      d = (phase(cur) - phase(m_prev) + 4) % 4;
      if (d == 1) begin m_cnt_en = 1; m_updown = 1; end
      else if (d == 3) begin m_cnt_en = 1; m_updown = 0; end
      else if (d == 2) illegal = 1'b1;
      m_prev = cur;
    end
    if (illegal) m_err = 1'b1;
    else if (Err_Clr) m_err = 1'b0;
    m_cnt_sclr = m_f[2] && !m_idx_prev && Idx_En;
    m_idx_prev = m_f[2];
    if (!m_ready && m_n >= SYNC + FILT && window_const(0) && window_const(1)) begin
      m_ready = 1'b1;
      m_prev  = {syn(m_n, 0), syn(m_n, 1)};
    end
    for (int c = 0; c < 3; c++) begin
      if (m_n >= FILT) begin
        flip = 1'b1;
        for (int k = 0; k < FILT; k++)
          if (syn(m_n - k, c) == m_f[c]) flip = 1'b0;
        if (flip) m_f[c] = !m_f[c];
      end
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    chk("cnt_en",   Cnt_En,   m_cnt_en);
    chk("updown",   UpDown,   m_updown);
    chk("cnt_sclr", Cnt_Sclr, m_cnt_sclr);
    chk("ready",    Ready,    m_ready);
    chk("err",      Err,      m_err);
    if (Cnt_Sclr === 1'b1) begin
      tb_pos = 16'h0000;
      n_clr++;
    end else if (Cnt_En === 1'b1) begin
      if (UpDown === 1'b1) begin tb_pos = tb_pos + 16'd1; n_up++; end
      else begin tb_pos = tb_pos - 16'd1; n_dn++; end
    end
  endtask

  task automatic hold(input logic [1:0] ab, input int cycles);
    {A, B} = ab;
    repeat (cycles) tick();
  endtask

  task automatic clear_tally();
    n_up = 0; n_dn = 0; n_clr = 0;
  endtask

  logic [1:0] up_seq[4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] dn_seq[5]  = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
  int first_clr;
  int hold_len;

  initial begin
    // Reset state
    Sclr = 1'b1;
    tick(); tick();
    chk("rst_cnt_en", Cnt_En, 1'b0);
    chk("rst_updown", UpDown, 1'b1);
    chk("rst_cnt_sclr", Cnt_Sclr, 1'b0);
    chk("rst_ready", Ready, 1'b0);
    chk("rst_err", Err, 1'b0);

    // Priming with AB=00: Ready on the sixth edge after reset
    Sclr = 1'b0;
    {A, B} = 2'b00;
    repeat (5) tick();
    chk("ready_before_6", Ready, 1'b0);
    tick();
    chk("ready_at_6", Ready, 1'b1);
    repeat (14) tick();

    // Up rotation
    tb_pos = 16'h0000;
    clear_tally();
    foreach (up_seq[i]) hold(up_seq[i], 12);
    chk("up_pulses", n_up, 4);
    chk("up_dn_pulses", n_dn, 0);
    chk("up_pos", tb_pos, 16'h0004);
    chk("up_dir", UpDown, 1'b1);

    // Reverse rotation wraps below zero
    clear_tally();
    foreach (dn_seq[i]) hold(dn_seq[i], 12);
    chk("dn_pulses", n_dn, 5);
    chk("dn_pos", tb_pos, 16'hFFFF);
    chk("dn_dir", UpDown, 1'b0);

    // A glitches from AB=01: 3 cycles rejected, 4 cycles passes both ways
    clear_tally();
    hold(2'b11, 3);
    hold(2'b01, 15);
    chk("glitch3_pulses", n_up + n_dn, 0);
    hold(2'b11, 4);
    hold(2'b01, 15);
    chk("pulse4_pulses", n_up + n_dn, 2);
    chk("pulse4_pos", tb_pos, 16'hFFFF);

    // Illegal double change, sticky through a valid edge, then cleared
    clear_tally();
    hold(2'b10, 12);
    chk("illegal_err", Err, 1'b1);
    chk("illegal_no_pulse", n_up + n_dn, 0);
    hold(2'b11, 12);
    chk("err_sticky", Err, 1'b1);
    chk("after_err_up", n_up, 1);
    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    chk("err_cleared", Err, 1'b0);

    // Index clear with Idx_En=1, then suppressed with Idx_En=0
    clear_tally();
    first_clr = 0;
    Idx_En = 1'b1;
    Idx = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 11) Idx = 1'b0;
      tick();
      if (Cnt_Sclr === 1'b1 && first_clr == 0) first_clr = i;
    end
    chk("idx_pulses", n_clr, 1);
    chk("idx_latency", first_clr, 7);
    chk("idx_pos", tb_pos, 16'h0000);
    clear_tally();
    Idx_En = 1'b0;
    Idx = 1'b1;
    repeat (10) tick();
    Idx = 1'b0;
    repeat (15) tick();
    chk("idx_suppressed", n_clr, 0);

    // Sclr mid-rotation with AB=11
    {A, B} = 2'b11;
    Sclr = 1'b1;
    tick();
    Sclr = 1'b0;
    chk("mid_rst_cnt_en", Cnt_En, 1'b0);
    chk("mid_rst_updown", UpDown, 1'b1);
    chk("mid_rst_ready", Ready, 1'b0);
    chk("mid_rst_err", Err, 1'b0);
    clear_tally();
    repeat (5) tick();
    chk("mid_ready_before_6", Ready, 1'b0);
    tick();
    chk("mid_ready_at_6", Ready, 1'b1);
    repeat (10) tick();
    chk("mid_no_pulse", n_up + n_dn, 0);
    chk("mid_no_err", Err, 1'b0);

    // Random traffic against the model
    for (int s = 0; s < 220; s++) begin
      A      = 1'($urandom_range(0, 1));
      B      = 1'($urandom_range(0, 1));
      Idx    = 1'($urandom_range(0, 1));
      Idx_En = 1'($urandom_range(0, 1));
      hold_len = $urandom_range(1, 12);
      repeat (hold_len) begin
        Err_Clr = ($urandom_range(0, 15) == 0);
        Sclr    = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    Sclr = 1'b0;
    Err_Clr = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
